// File: rtl/mem_port_arbiter.sv
// Two-requester main-memory port arbiter: round-robin grant, fixed BEATS-word bursts, done routing.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      wr0,
  input  logic                      wr1,
  input  logic [ADDR_W-1:0]         addr0,
  input  logic [ADDR_W-1:0]         addr1,
  input  logic [DATA_W-1:0]         wdata0,
  input  logic [DATA_W-1:0]         wdata1,
  output logic                      gnt0,
  output logic                      gnt1,
  output logic [$clog2(BEATS)-1:0]  beat,
  output logic                      beat_ack,
  output logic                      burst_end,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_valid,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_done,
  output logic                      err
);

  localparam int BW = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t               state, state_nx;
  logic                 owner, owner_nx;
  logic                 ptr, ptr_nx;
  logic                 wr_q, wr_nx;
  logic [ADDR_W-1:BW+2] base_q, base_nx;
  logic [BW-1:0]        beat_q, beat_nx;
  logic                 busy, win, last_beat, timeout_hit;

  // Word offset bits of the request address are replaced by the beat index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[BW+1:0], addr1[BW+1:0]};

  assign busy      = (state == BUSY);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign win       = (req0 && req1) ? ptr : req1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if (!busy || mem_done)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th consecutive silent BUSY cycle; a same-cycle done wins.
  assign timeout_hit = busy && !mem_done && (idle_cnt == TW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      wr_q   <= 1'b0;
      base_q <= '0;
      beat_q <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      ptr    <= ptr_nx;
      wr_q   <= wr_nx;
      base_q <= base_nx;
      beat_q <= beat_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    wr_nx    = wr_q;
    base_nx  = base_q;
    beat_nx  = beat_q;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nx = win;
          wr_nx    = win ? wr1 : wr0;
          base_nx  = win ? addr1[ADDR_W-1:BW+2] : addr0[ADDR_W-1:BW+2];
          beat_nx  = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (mem_done && !last_beat) begin
          beat_nx = beat_q + 1'b1;
        end else if (mem_done || timeout_hit) begin
          beat_nx  = '0;
          ptr_nx   = ~owner;
          state_nx = RELEASE;
        end
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign gnt0      = busy && !owner;
  assign gnt1      = busy && owner;
  assign beat      = beat_q;
  assign beat_ack  = busy && mem_done;
  assign burst_end = (beat_ack && last_beat) || timeout_hit;
  assign err       = timeout_hit;
  assign rdata     = mem_rdata;
  assign mem_valid = busy;
  assign mem_write = busy && wr_q;
  assign mem_addr  = busy ? {base_q, beat_q, 2'b00} : '0;
  assign mem_wdata = !busy ? '0 : (owner ? wdata1 : wdata0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
// Define MEM_ARB_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int BW     = 2;
  localparam int TO     = 8;
  localparam int VW     = 7 + ADDR_W + BW + 2 * DATA_W;

  typedef struct {logic wr; logic [ADDR_W-1:0] addr;} burst_t;

  logic              clock, reset_n;
  logic              req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, beat_ack, burst_end, mem_valid, mem_write, err;
  logic [BW-1:0]     beat;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .beat(beat), .beat_ack(beat_ack), .burst_end(burst_end),
    .rdata(rdata), .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester work queues and memory-responder knobs.
  burst_t q0[$], q1[$];
  logic   hold1 = 1'b0;
  logic   spur = 1'b0, rd_fixed = 1'b0;
  int     period = 0, stall_at = BEATS, ack_cnt = 0;

  // Reference model: owner -1 = port free, dead = turnaround cycle after a burst.
  int                m_owner, m_words, m_ptr, m_tcnt;
  logic              m_dead, m_wr;
  logic [ADDR_W-1:0] m_base;

  function automatic int pick();
    return (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
  endfunction

  function automatic logic model_timeout();
`ifdef MEM_ARB_TIMEOUT_EN
    return (m_owner >= 0) && !mem_done && (m_tcnt == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1; m_words <= 0; m_ptr <= 0; m_tcnt <= 0; m_dead <= 1'b0;
      m_wr <= 1'b0; m_base <= '0;
    end else if (m_dead) begin
      m_dead <= 1'b0;
    end else if (m_owner < 0) begin
      if (req0 || req1) begin
        m_owner <= pick();
        m_wr    <= (pick() == 1) ? wr1 : wr0;
        m_base  <= (pick() == 1) ? addr1 : addr0;
        m_words <= 0;
        m_tcnt  <= 0;
      end
    end else if ((mem_done && m_words == BEATS - 1) || model_timeout()) begin
      m_ptr   <= 1 - m_owner;
      m_owner <= -1;
      m_words <= 0;
      m_dead  <= 1'b1;
      if (m_owner == 0 && q0.size() > 0) void'(q0.pop_front());
      if (m_owner == 1 && q1.size() > 0) void'(q1.pop_front());
    end else if (mem_done) begin
      m_words <= m_words + 1;
      m_tcnt  <= 0;
    end else begin
      m_tcnt <= m_tcnt + 1;
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic busy, e_ack, e_to, e_end;
    logic [ADDR_W-1:0] e_addr;
    logic [BW-1:0] e_beat;
    logic [DATA_W-1:0] e_wd;
    busy   = (m_owner >= 0);
    e_ack  = busy && mem_done;
    e_to   = model_timeout();
    e_end  = (e_ack && m_words == BEATS - 1) || e_to;
    e_addr = busy ? ADDR_W'((int'(m_base) / (BEATS * 4)) * (BEATS * 4) + m_words * 4) : '0;
    e_beat = busy ? BW'(m_words) : '0;
    e_wd   = !busy ? '0 : ((m_owner == 0) ? wdata0 : wdata1);
    return {m_owner == 0, m_owner == 1, busy, busy && m_wr, e_ack, e_end, e_to,
            e_addr, e_beat, e_wd, mem_rdata};
  endfunction

  logic [VW-1:0] obs_vec;
  assign obs_vec = {gnt0, gnt1, mem_valid, mem_write, beat_ack, burst_end, err, mem_addr,
                    (m_owner >= 0) ? beat : 2'b00, (m_owner >= 0) ? mem_wdata : 32'h0, rdata};

  function automatic logic model_idle();
    return q0.size() == 0 && q1.size() == 0 && m_owner < 0 && !m_dead;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Requester and memory agents; they drive on the falling edge.
  initial begin
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; mem_rdata = '0; mem_done = 0;
    forever begin
      @(negedge clock);
      req0 = q0.size() > 0;
      req1 = q1.size() > 0 && !hold1;
      if (q0.size() > 0 && m_owner != 0) begin wr0 = q0[0].wr; addr0 = q0[0].addr; end
      else begin wr0 = 1'($urandom); addr0 = ADDR_W'($urandom); end
      if (q1.size() > 0 && m_owner != 1) begin wr1 = q1[0].wr; addr1 = q1[0].addr; end
      else begin wr1 = 1'($urandom); addr1 = ADDR_W'($urandom); end
      wdata0    = $urandom;
      wdata1    = $urandom;
      mem_rdata = rd_fixed ? 32'hA0 + 32'(m_words) : $urandom;
      if (m_owner >= 0 && m_words < stall_at) begin
        if (period == 0) mem_done = 1'($urandom_range(0, 1));
        else begin
          ack_cnt++;
          mem_done = (ack_cnt == period);
          if (mem_done) ack_cnt = 0;
        end
      end else begin
        ack_cnt  = 0;
        mem_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_tests++;
    if ({gnt0, gnt1, mem_valid, mem_write, mem_addr, beat, err, beat_ack, burst_end} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0",
               {gnt0, gnt1, mem_valid, mem_write, mem_addr, beat, err, beat_ack, burst_end});
    end
    repeat (2) @(negedge clock);
    #1;
    n_tests++;
    if (obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h want=%h", obs_vec, exp_vec());
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [ADDR_W-1:0] a_log[$];
    logic [DATA_W-1:0] d_log[$];
    int ends = 0;
    period = 3; rd_fixed = 1; spur = 0;
    @(negedge clock); #2;
    q0.push_back('{1'b0, 10'h13C});
    for (int c = 0; c < 60; c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL single_read_cyc%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (c == 1) begin
        n_tests++;
        if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_read_grant got=%b want=1", gnt0); end
      end
      if (beat_ack) begin a_log.push_back(mem_addr); d_log.push_back(rdata); end
      if (burst_end) ends++;
      if (c > 2 && model_idle()) break;
    end
    n_tests++;
    if (a_log.size() != 4 || ends != 1) begin
      n_fail++; $display("FAIL single_read_count got=%0d/%0d want=4/1", a_log.size(), ends);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (a_log[k] !== ADDR_W'(10'h130 + 4 * k) || d_log[k] !== DATA_W'(32'hA0 + k)) begin
          n_fail++;
          $display("FAIL single_read_beat%0d got=%h/%h want=%h/%h", k, a_log[k], d_log[k],
                   10'h130 + 4 * k, 32'hA0 + k);
        end
      end
    end
    rd_fixed = 0;
  endtask

  task automatic test_writeback_fill();
    int k = 0;
    period = 0; spur = 0;
    @(negedge clock); #2;
    q0.push_back('{1'b1, 10'h2A0});
    q0.push_back('{1'b0, 10'h1F0});
    for (int c = 0; c < 200 && !(c > 2 && model_idle()); c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL wb_fill_cyc%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (beat_ack) begin
        n_tests++;
        if (k < 4 ? (mem_write !== 1'b1 || mem_addr !== ADDR_W'(10'h2A0 + 4 * k))
                  : (mem_write !== 1'b0 || mem_addr !== ADDR_W'(10'h1F0 + 4 * (k - 4)))) begin
          n_fail++; $display("FAIL wb_fill_ack%0d got=%b/%h", k, mem_write, mem_addr);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 8 || !model_idle()) begin
      n_fail++; $display("FAIL wb_fill_acks got=%0d want=8", k);
    end
  endtask

  task automatic test_contention();
    int order[$];
    int overlap = 0;
    logic p0 = 0, p1 = 0;
    period = 0; spur = 0;
    @(negedge clock); reset_n = 0; #2; reset_n = 1;
    @(negedge clock); #2;
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{1'($urandom), ADDR_W'($urandom)});
      q1.push_back('{1'($urandom), ADDR_W'($urandom)});
    end
    for (int c = 0; c < 300 && !(c > 2 && model_idle()); c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL contention_cyc%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (gnt0 && !p0) order.push_back(0);
      if (gnt1 && !p1) order.push_back(1);
      if (gnt0 && gnt1) overlap++;
      p0 = gnt0; p1 = gnt1;
    end
    n_tests++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1
        || overlap != 0) begin
      n_fail++; $display("FAIL contention_order got=%p overlap=%0d want='{0,1,0,1}", order, overlap);
    end
  endtask

  task automatic test_spurious_drop();
    int acks = 0;
    period = 1; spur = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (beat_ack !== 1'b0 || obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL spurious_idle got=%b want=0", beat_ack);
      end
    end
    spur = 0;
    @(negedge clock); #2;
    q1.push_back('{1'b0, ADDR_W'($urandom)});
    for (int c = 0; c < 100 && !(c > 2 && model_idle()); c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL early_drop_cyc%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (beat_ack && gnt1) begin
        acks++;
        if (beat == 2'd1) hold1 = 1'b1;
      end
    end
    n_tests++;
    if (acks != 4 || !model_idle() || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL early_drop_acks got=%0d want=4", acks);
    end
    hold1 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int first = -1;
    int c;
    period = 2; spur = 0;
    @(negedge clock); #2;
    q0.push_back('{1'b1, ADDR_W'($urandom)});
    for (c = 0; c < 50 && !(gnt0 && beat == 2'd2); c++) begin
      @(negedge clock); #1;
      if (gnt0 && q1.size() == 0) q1.push_back('{1'b0, ADDR_W'($urandom)});
    end
    n_tests++;
    if (!(gnt0 && beat == 2'd2)) begin n_fail++; $display("FAIL reset_mid_reach got=%0d want=2", beat); end
    #1;
    reset_n = 1'b0;
    q0.delete();
    #1;
    n_tests++;
    if ({gnt0, gnt1, mem_valid, mem_write, mem_addr, beat, err, beat_ack, burst_end} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b want=0",
               {gnt0, gnt1, mem_valid, mem_write, mem_addr, beat, err, beat_ack, burst_end});
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (c = 0; c < 100 && !(c > 2 && model_idle()); c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_mid_cyc%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (first < 0 && (gnt0 || gnt1)) first = gnt1 ? 1 : 0;
    end
    n_tests++;
    if (first != 1) begin n_fail++; $display("FAIL reset_mid_first got=%0d want=1", first); end
  endtask

  task automatic test_random();
    period = 0; spur = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_cyc%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (c < 500 && $urandom_range(0, 7) == 0 && q0.size() < 2)
        q0.push_back('{1'($urandom), ADDR_W'($urandom)});
      if (c < 500 && $urandom_range(0, 7) == 0 && q1.size() < 2)
        q1.push_back('{1'($urandom), ADDR_W'($urandom)});
      if (c >= 500 && model_idle()) break;
    end
    spur = 0;
    n_tests++;
    if (!model_idle()) begin n_fail++; $display("FAIL random_drain got=busy want=idle"); end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int last_ack = -1, err_cyc = -1, errs = 0, after = -1;
    period = 1; stall_at = 2; spur = 0;
    @(negedge clock); #2;
    q0.push_back('{1'b0, ADDR_W'($urandom)});
    q1.push_back('{1'b0, ADDR_W'($urandom)});
    for (int c = 0; c < 200 && !(c > 2 && model_idle()); c++) begin
      @(negedge clock); #1;
      n_tests++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL timeout_cyc%0d got=%h want=%h", c, obs_vec, exp_vec());
      end
      if (beat_ack && err_cyc < 0) last_ack = c;
      if (err) begin errs++; err_cyc = c; stall_at = BEATS; end
      if (err_cyc >= 0 && c > err_cyc && after < 0 && (gnt0 || gnt1)) after = gnt1 ? 1 : 0;
    end
    n_tests++;
    if (errs != 1 || err_cyc - last_ack != TO || after != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse got=errs%0d dist%0d next%0d want=errs1 dist%0d next1",
               errs, err_cyc - last_ack, after, TO);
    end
    stall_at = BEATS;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_writeback_fill();
    test_contention();
    test_spurious_drop();
    test_reset_mid_burst();
    test_random();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
